// File: rtl/button_conditioner_if.sv
// Button bundle between the board pins and the movement block.
// The master drives the raw buttons and receives the strobes.
// The slave (the conditioner) takes the raw buttons and returns the strobes.
interface button_conditioner_if;
    logic up_in;
    logic down_in;
    logic left_in;
    logic right_in;
    logic up;
    logic down;
    logic left;
    logic right;

    modport master (
        output up_in, down_in, left_in, right_in,
        input  up, down, left, right
    );

    modport slave (
        input  up_in, down_in, left_in, right_in,
        output up, down, left, right
    );
endinterface

// File: rtl/button_conditioner.sv
// Conditions the four raw direction buttons in these stages:
//   two-flop synchroniser -> debounce -> priority arbitration -> strobe FSM.
// The FSM emits one-hot strobes. Each strobe lasts PULSE_CYCLES so that a
// slow-clock sampler downstream can catch it.
// Optional feature macro: AUTO_REPEAT_EN.
//   Defined:   a held button auto-repeats (DELAY/REPEAT states).
//   Undefined: one strobe per press (WAIT_REL state).
// Bit order of all 4-bit vectors: [0]=up, [1]=down, [2]=left, [3]=right.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 40000000,
    parameter int REPEAT_RATE     = 25000000,
    parameter int PULSE_CYCLES    = 16777216,
    parameter int CNT_W           = 26
) (
    input  logic                clk,
    input  logic                rst,
    button_conditioner_if.slave btn
);

    // A strobe must end before the next strobe for the same press fires.
    // Otherwise the pulses would merge.
    if (REPEAT_DELAY <= PULSE_CYCLES || REPEAT_RATE <= PULSE_CYCLES) begin : g_bad_params
        $error("button_conditioner: REPEAT_DELAY and REPEAT_RATE must exceed PULSE_CYCLES");
    end

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT, WAIT_REL} state_t;

    logic [3:0] raw;
    logic [3:0] sync1_q, sync1_d;
    logic [3:0] sync2_q, sync2_d;
    logic [3:0] db_level;
    logic [3:0] dir;
    logic [3:0] strobe;

    assign raw = {btn.right_in, btn.left_in, btn.down_in, btn.up_in};

    // Synchroniser next-state: shift the raw pins through two stages.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
    end

    // Synchroniser flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             lvl_q, lvl_d;

        // Count consecutive disagreeing cycles. The level flips on the
        // DEBOUNCE_CYCLES-th disagreeing edge. Any agreement clears the count.
        always_comb begin
            cnt_d = '0;
            lvl_d = lvl_q;
            if (sync2_q[gi] != lvl_q) begin
                if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1))
                    lvl_d = ~lvl_q;
                else
                    cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Debounce counter and level flops.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
                lvl_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                lvl_q <= lvl_d;
            end
        end

        assign db_level[gi] = lvl_q;
    end

    // Priority arbitration: up > down > left > right, one-hot or none.
    always_comb begin
        dir = 4'b0000;
        if (db_level[0])      dir = 4'b0001;
        else if (db_level[1]) dir = 4'b0010;
        else if (db_level[2]) dir = 4'b0100;
        else if (db_level[3]) dir = 4'b1000;
    end

    state_t           state_q, state_d;
    logic [3:0]       latched_q, latched_d;
    logic [3:0]       out_dir_q, out_dir_d;
    logic [CNT_W-1:0] pulse_q, pulse_d;
    logic             fire;
`ifdef AUTO_REPEAT_EN
    logic [CNT_W-1:0] timer_q, timer_d;
`endif

    // Strobe FSM: choose the next state, decide when to fire, and run the pulse stretcher.
    always_comb begin
        state_d   = state_q;
        latched_d = latched_q;
        fire      = 1'b0;
`ifdef AUTO_REPEAT_EN
        timer_d   = timer_q;
`endif
        case (state_q)
            IDLE: begin
                if (dir != 4'b0000) begin
                    latched_d = dir;
                    fire      = 1'b1;
`ifdef AUTO_REPEAT_EN
                    timer_d   = '0;
                    state_d   = DELAY;
`else
                    state_d   = WAIT_REL;
`endif
                end
            end
`ifdef AUTO_REPEAT_EN
            // A release or a change of direction wins over a due repeat.
            // The check also covers dir == none, because latched_q is never zero here.
            DELAY: begin
                if (dir != latched_q) begin
                    state_d = IDLE;
                end else if (timer_q == CNT_W'(REPEAT_DELAY - 1)) begin
                    fire    = 1'b1;
                    timer_d = '0;
                    state_d = REPEAT;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            REPEAT: begin
                if (dir != latched_q) begin
                    state_d = IDLE;
                end else if (timer_q == CNT_W'(REPEAT_RATE - 1)) begin
                    fire    = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
`else
            WAIT_REL: begin
                if (dir == 4'b0000) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase

        // A fire restarts the stretcher and replaces the direction.
        // This keeps the outputs one-hot.
        out_dir_d = out_dir_q;
        pulse_d   = pulse_q;
        if (fire) begin
            out_dir_d = latched_d;
            pulse_d   = CNT_W'(PULSE_CYCLES);
        end else if (pulse_q != '0) begin
            pulse_d = pulse_q - CNT_W'(1);
        end
    end

    // FSM, latched direction, pulse stretcher and repeat timer flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            latched_q <= '0;
            out_dir_q <= '0;
            pulse_q   <= '0;
`ifdef AUTO_REPEAT_EN
            timer_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            latched_q <= latched_d;
            out_dir_q <= out_dir_d;
            pulse_q   <= pulse_d;
`ifdef AUTO_REPEAT_EN
            timer_q   <= timer_d;
`endif
        end
    end

    // Output gating: strobes come straight from flops. An async reset therefore drops them at once.
    always_comb begin
        strobe = (pulse_q != '0) ? out_dir_q : 4'b0000;
    end

    assign btn.up    = strobe[0];
    assign btn.down  = strobe[1];
    assign btn.left  = strobe[2];
    assign btn.right = strobe[3];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with small timing parameters.
// Per-cycle stimulus and expected outputs are tables indexed by clock edge k.
// Edge 0 is the first edge after reset release.
// Outputs are sampled 1 time unit after each edge.
// Vector bit order: [0]=up, [1]=down, [2]=left, [3]=right.
module tb_button_conditioner;
    localparam int DEB  = 4;
    localparam int RDLY = 20;
    localparam int RRATE = 8;
    localparam int PULSE = 2;
    localparam int CW   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    button_conditioner_if bus ();

    button_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RDLY),
        .REPEAT_RATE     (RRATE),
        .PULSE_CYCLES    (PULSE),
        .CNT_W           (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .btn (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [3:0] btn_v [0:127];
    logic [3:0] exp_v [0:127];
    logic [3:0] outs;
    assign outs = {bus.right, bus.left, bus.down, bus.up};

    task automatic set_btn(input logic [3:0] b);
        bus.up_in    = b[0];
        bus.down_in  = b[1];
        bus.left_in  = b[2];
        bus.right_in = b[3];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset is released 1 unit after an edge. The next edge is edge 0.
    task automatic apply_reset();
        rst = 1'b1;
        set_btn(4'b0000);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic clear_tables();
        for (int i = 0; i < 128; i++) begin
            btn_v[i] = 4'b0000;
            exp_v[i] = 4'b0000;
        end
    endtask

    // Button value b is seen at edges lo..hi (inclusive).
    task automatic press(input int lo, input int hi, input logic [3:0] b);
        for (int i = lo; i <= hi; i++) btn_v[i] = btn_v[i] | b;
    endtask

    // A strobe fired at edge r is high after edges r .. r+PULSE-1.
    task automatic add_strobe(input int r, input logic [3:0] b);
        for (int i = r; i < r + PULSE; i++) exp_v[i] = exp_v[i] | b;
    endtask

    task automatic test_reset();
        set_btn(4'b0000);
        rst = 1'b1;
        #1;
        checks++;
        if (outs !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs got=%b expected=%b", outs, 4'b0000);
        end
        // Buttons pressed while reset is held must never propagate.
        set_btn(4'b1111);
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (outs !== 4'b0000) begin
                errors++;
                $display("FAIL reset_held k=%0d got=%b expected=%b", k, outs, 4'b0000);
            end
        end
        set_btn(4'b0000);
        $display("test_reset: done");
    endtask

    // up pressed for edges 0..9: strobe fires at edge DEB+2 = 6 and lasts 2 cycles.
    task automatic test_single_press();
        clear_tables();
        press(0, 9, 4'b0001);
        add_strobe(6, 4'b0001);
        apply_reset();
        for (int k = 0; k < 30; k++) begin
            set_btn(btn_v[k]);
            tick();
            checks++;
            if (outs !== exp_v[k]) begin
                errors++;
                $display("FAIL single_press k=%0d got=%b expected=%b", k, outs, exp_v[k]);
            end
        end
        $display("test_single_press: 30 cycles");
    endtask

    // A 3-cycle glitch is shorter than DEB, so nothing may ever fire.
    task automatic test_glitch();
        clear_tables();
        press(0, 2, 4'b0100);
        apply_reset();
        for (int k = 0; k < 20; k++) begin
            set_btn(btn_v[k]);
            tick();
            checks++;
            if (outs !== exp_v[k]) begin
                errors++;
                $display("FAIL glitch k=%0d got=%b expected=%b", k, outs, exp_v[k]);
            end
        end
        $display("test_glitch: 20 cycles");
    endtask

`ifdef AUTO_REPEAT_EN
    // right is seen at edges 0..59, so the debounced level falls at edge 65.
    // Strobes fire at 6, then 6+20, then every 8 cycles: 26, 34, 42, 50, 58.
    // At edge 66 a repeat would be due, but the release is seen first and wins.
    task automatic test_auto_repeat();
        clear_tables();
        press(0, 59, 4'b1000);
        add_strobe(6, 4'b1000);
        add_strobe(26, 4'b1000);
        add_strobe(34, 4'b1000);
        add_strobe(42, 4'b1000);
        add_strobe(50, 4'b1000);
        add_strobe(58, 4'b1000);
        apply_reset();
        for (int k = 0; k < 90; k++) begin
            set_btn(btn_v[k]);
            tick();
            checks++;
            if (outs !== exp_v[k]) begin
                errors++;
                $display("FAIL auto_repeat k=%0d got=%b expected=%b", k, outs, exp_v[k]);
            end
        end
        $display("test_auto_repeat: 90 cycles");
    endtask
`else
    // One strobe per press: right is seen at edges 0..39 and again at 50..69.
    // The debounced level falls at edge 45 and the FSM is back in IDLE at edge 46.
    // The re-press then fires at edge 50+6 = 56.
    task automatic test_single_shot();
        clear_tables();
        press(0, 39, 4'b1000);
        press(50, 69, 4'b1000);
        add_strobe(6, 4'b1000);
        add_strobe(56, 4'b1000);
        apply_reset();
        for (int k = 0; k < 100; k++) begin
            set_btn(btn_v[k]);
            tick();
            checks++;
            if (outs !== exp_v[k]) begin
                errors++;
                $display("FAIL single_shot k=%0d got=%b expected=%b", k, outs, exp_v[k]);
            end
        end
        $display("test_single_shot: 100 cycles");
    endtask
`endif

    // down is seen at edges 0..29; up is added at edges 15..29.
    // The up debounced level rises at edge 20.
    // With repeat: DELAY drops to IDLE at edge 21 and up fires at edge 22.
    // Without repeat: WAIT_REL ignores the change, so no up strobe.
    task automatic test_priority();
        clear_tables();
        press(0, 29, 4'b0010);
        press(15, 29, 4'b0001);
        add_strobe(6, 4'b0010);
`ifdef AUTO_REPEAT_EN
        add_strobe(22, 4'b0001);
`endif
        apply_reset();
        for (int k = 0; k < 60; k++) begin
            set_btn(btn_v[k]);
            tick();
            checks++;
            if (outs !== exp_v[k]) begin
                errors++;
                $display("FAIL priority k=%0d got=%b expected=%b", k, outs, exp_v[k]);
            end
        end
        $display("test_priority: 60 cycles");
    endtask

    // Reset asserted between edges while the up strobe is high.
    task automatic test_reset_mid_strobe();
        apply_reset();
        set_btn(4'b0001);
        for (int k = 0; k <= 6; k++) tick();
        checks++;
        if (outs !== 4'b0001) begin
            errors++;
            $display("FAIL mid_strobe_pre got=%b expected=%b", outs, 4'b0001);
        end
        #2;
        rst = 1'b1;
        set_btn(4'b0000);
        #1;
        checks++;
        if (outs !== 4'b0000) begin
            errors++;
            $display("FAIL mid_strobe_async got=%b expected=%b", outs, 4'b0000);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if (outs !== 4'b0000) begin
                errors++;
                $display("FAIL mid_strobe_after k=%0d got=%b expected=%b", k, outs, 4'b0000);
            end
        end
        $display("test_reset_mid_strobe: done");
    endtask

    initial begin
        if (RDLY <= PULSE || RRATE <= PULSE) begin
            $display("FAIL param_legality delay=%0d rate=%0d pulse=%0d", RDLY, RRATE, PULSE);
            $fatal(1);
        end
        set_btn(4'b0000);
        test_reset();
        test_single_press();
        test_glitch();
`ifdef AUTO_REPEAT_EN
        test_auto_repeat();
`else
        test_single_shot();
`endif
        test_priority();
        test_reset_mid_strobe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
